note_scheduler: RTL
===================

Name: note_scheduler

Overview:
Sequences the tone generator. Drives its octave and note inputs from one of two sources: live piano keys, or a built-in demo melody started by a button. Live keys always pre-empt the melody. Among several held keys, the most recently pressed key wins. Sits between board switches/buttons and the tone generator; note code 0 means silence.

Parameters:
BEAT_CYCLES, 25000000, clk_100M cycles per melody beat (250 ms at 100 MHz)
GAP_CYCLES, 2500000, silent cycles inserted after every melody note
SONG_LEN, 8, number of melody ROM entries (fixed table below; must be 8)

Ports:
clk_100M  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
keys  input  7  raw key levels; bit i = note code i+1 (C..B); asynchronous
octave_sw  input  3  raw octave switches; asynchronous
play_btn  input  1  raw demo-start button; asynchronous, level
octave  output  3  octave to tone generator
note  output  3  note code to tone generator; 0 = silence
live  output  1  1 while in LIVE state
playing  output  1  1 while in SEQ_NOTE or SEQ_GAP

Behaviour:
- Clock and reset: one clock, clk_100M. Reset is asynchronous and active-low, rst_n. All flops clear on reset.
- Reset values: octave=0, note=0, live=0, playing=0. Synchronizer stages=0, prev-key mask=0, counters=0, state=IDLE.
- Input sync: keys, octave_sw and play_btn each pass through a 2-FF synchronizer. The sync outputs are ks, os and ps.
- play_btn edge: play_rise = ps & ~ps_d, where ps_d is ps delayed one cycle.
- Key edges: new = ks & ~prev_ks; prev_ks <= ks every cycle.
- Live selection register sel (3 bits, note code):
  - If new != 0: sel = lowest set index of new, plus 1.
  - Else if the currently selected key is released: sel = lowest held index plus 1, or 0 if none held.
- States and transitions:
  - IDLE: ks != 0 -> LIVE. play_rise -> SEQ_NOTE with idx=0 and the melody start snapshot.
  - LIVE: note <= sel; octave <= os (octave tracks switches live). ks == 0 -> IDLE with note <= 0. play_rise is ignored while ks != 0.
  - SEQ_NOTE: outputs the ROM entry; counter runs to beats*BEAT_CYCLES-1, then -> SEQ_GAP with note <= 0.
  - SEQ_GAP: counter runs to GAP_CYCLES-1, then:
    - idx == SONG_LEN-1 -> IDLE (see Optional Feature);
    - otherwise idx+1 -> SEQ_NOTE.
  - Any ks != 0 in SEQ_NOTE or SEQ_GAP: abort -> LIVE the same cycle. idx and counter clear; playing drops.
  - play_rise in SEQ_NOTE or SEQ_GAP: stop -> IDLE with note <= 0.
- Melody start snapshot: base = os, captured at the play_rise that starts the melody. Later switch changes do not affect a running melody.
- Melody ROM, entry i = {note, octave offset, beats}:
  - i=0..6: note i+1, offset 0, 1 beat.
  - i=7: note 1, offset 1, 2 beats.
  - Entry octave = base + offset, saturating at 7.
- Counter: 32-bit. Cleared on every state entry.
- Latency: raw key edge -> note output change in exactly 3 cycles (2 sync + 1 output register). play_btn edge -> first melody note in 4 cycles.
- Simultaneous events: ks != 0 has priority over play_rise, which has priority over counter expiry. In LIVE, simultaneous new presses resolve to the lowest index.

Optional Feature:
Macro NOTE_SCHED_LOOP_EN.
- Defined: at the end of SEQ_GAP for idx == SONG_LEN-1, go to SEQ_NOTE with idx=0, keeping the captured base. The melody repeats until play_rise or a key press.
- Undefined: a single pass, then IDLE; note=0, playing=0.

Test Plan:
- Reset: assert rst_n=0 mid-melody -> same cycle octave=0, note=0, live=0, playing=0; after release, remains IDLE.
- Live priority: octave_sw=3, press keys[2] (E); 10 cycles later also press keys[4] (G); then release keys[4] -> note 3, then note 5 3 cycles after the G edge, then note 3 again 3 cycles after the release; octave=3 throughout; release all -> note=0, live=0.
- Melody (BEAT_CYCLES=10, GAP_CYCLES=2, octave_sw=2): pulse play_btn -> notes 1..7 each held 10 cycles with octave 2, each followed by 2 cycles of note 0; then note 1, octave 3 for 20 cycles; then IDLE, playing=0.
- Saturation: octave_sw=7, run melody -> entry 7 outputs octave 7, not 0.
- Pre-emption: during entry 3, press keys[0] -> within 3 cycles note=1, live=1, playing=0. Release, then press play -> melody restarts at entry 0.
- Loop (NOTE_SCHED_LOOP_EN defined): let melody finish -> after the final gap, note=1 with base octave; second play pulse -> IDLE, note=0.

Source files
------------

// File: rtl/note_scheduler.sv
// Picks the tone generator's octave/note from live piano keys or a built-in 8-note demo melody.
// Build with NOTE_SCHED_LOOP_EN defined to repeat the melody until stopped, otherwise it plays once.
module note_scheduler #(
  parameter int unsigned BEAT_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 2500000,
  parameter int unsigned SONG_LEN    = 8
) (
  input  logic       clk_100M,
  input  logic       rst_n,
  input  logic [6:0] keys,
  input  logic [2:0] octave_sw,
  input  logic       play_btn,
  output logic [2:0] octave,
  output logic [2:0] note,
  output logic       live,
  output logic       playing
);

  typedef enum logic [1:0] {IDLE, LIVE, SEQ_NOTE, SEQ_GAP} state_e;

  localparam logic [31:0] BEAT1_LIM = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0] BEAT2_LIM = 32'(2 * BEAT_CYCLES - 1);
  localparam logic [31:0] GAP_LIM   = 32'(GAP_CYCLES - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(SONG_LEN - 1);

  state_e      state_q, state_d;
  logic [6:0]  keys_s1_q, ks_q, prev_ks_q;
  logic [2:0]  oct_s1_q, os_q;
  logic        play_s1_q, ps_q, ps_dly_q;
  logic [2:0]  sel_q, sel_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  base_q, base_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  note_q, note_d;
  logic [2:0]  octave_q, octave_d;

  logic        any_key, play_rise;
  logic [6:0]  new_keys;
  logic        two_beats;
  logic [3:0]  oct_sum;
  logic [2:0]  rom_oct;
  logic [2:0]  rom_note;

  function automatic logic [2:0] lowest_code(input logic [6:0] v);
    lowest_code = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) lowest_code = 3'(i + 1);
    end
  endfunction

  assign any_key   = |ks_q;
  assign play_rise = ps_q & ~ps_dly_q;
  assign new_keys  = ks_q & ~prev_ks_q;

  // Melody table: notes C..B one beat each, then a two-beat C one octave up.
  assign two_beats = (idx_q == 3'd7);
  assign rom_note  = two_beats ? 3'd1 : idx_q + 3'd1;
  assign oct_sum   = {1'b0, base_q} + {3'b000, two_beats};
  assign rom_oct   = oct_sum[3] ? 3'd7 : oct_sum[2:0];

  // Most recent press wins; on release of the selected key fall back to the lowest one still held.
  always_comb begin
    sel_d = sel_q;
    if (new_keys != 7'd0) begin
      sel_d = lowest_code(new_keys);
    end else if (sel_q != 3'd0 && !ks_q[sel_q - 3'd1]) begin
      sel_d = lowest_code(ks_q);
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      keys_s1_q <= '0;
      ks_q      <= '0;
      prev_ks_q <= '0;
      oct_s1_q  <= '0;
      os_q      <= '0;
      play_s1_q <= 1'b0;
      ps_q      <= 1'b0;
      ps_dly_q  <= 1'b0;
      sel_q     <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      note_q    <= '0;
      octave_q  <= '0;
    end else begin
      state_q   <= state_d;
      keys_s1_q <= keys;
      ks_q      <= keys_s1_q;
      prev_ks_q <= ks_q;
      oct_s1_q  <= octave_sw;
      os_q      <= oct_s1_q;
      play_s1_q <= play_btn;
      ps_q      <= play_s1_q;
      ps_dly_q  <= ps_q;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      octave_q  <= octave_d;
    end
  end

  // Priority: held key, then play edge, then counter expiry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (any_key) begin
          state_d = LIVE;
        end else if (play_rise) begin
          state_d = SEQ_NOTE;
          idx_d   = 3'd0;
          base_d  = os_q;
        end
      end
      LIVE: begin
        if (!any_key) state_d = IDLE;
      end
      SEQ_NOTE: begin
        if (any_key) begin
          state_d = LIVE;
          idx_d   = 3'd0;
        end else if (play_rise) begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end else if (cnt_q == (two_beats ? BEAT2_LIM : BEAT1_LIM)) begin
          state_d = SEQ_GAP;
        end
      end
      SEQ_GAP: begin
        if (any_key) begin
          state_d = LIVE;
          idx_d   = 3'd0;
        end else if (play_rise) begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end else if (cnt_q == GAP_LIM) begin
          if (idx_q == LAST_IDX) begin
`ifdef NOTE_SCHED_LOOP_EN
            state_d = SEQ_NOTE;
`else
            state_d = IDLE;
`endif
            idx_d = 3'd0;
          end else begin
            state_d = SEQ_NOTE;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_d = (state_d != state_q) ? 32'd0 :
                 ((state_q == SEQ_NOTE || state_q == SEQ_GAP) ? cnt_q + 32'd1 : 32'd0);

  // A held key overrides every state so that pre-emption shows up in the same cycle as the abort.
  always_comb begin
    note_d   = 3'd0;
    octave_d = octave_q;
    case (state_q)
      SEQ_NOTE: begin
        if (any_key) begin
          note_d   = sel_d;
          octave_d = os_q;
        end else if (!play_rise) begin
          note_d   = rom_note;
          octave_d = rom_oct;
        end
      end
      default: begin
        if (any_key) begin
          note_d   = sel_d;
          octave_d = os_q;
        end
      end
    endcase
  end

  assign note    = note_q;
  assign octave  = octave_q;
  assign live    = (state_q == LIVE);
  assign playing = (state_q == SEQ_NOTE) || (state_q == SEQ_GAP);

endmodule
